// File: rtl/score_argmax_tracker_pkg.sv
// Shared types and helpers for the streaming top-2 score tracker.
// Latency: n/a (types, constants and a pure compare function only).
// Backpressure: n/a.
package score_argmax_tracker_pkg;

    // Frame geometry and score width are fixed here because top2_t is built from them.
    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 16;
    localparam int IDX_W       = $clog2(NUM_CLASSES);

    // FSM encoding: accumulate beats, then one dead cycle to commit the frame.
    localparam logic [0:0] ST_ACCUM  = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;

    // Running best / runner-up of the frame in flight.
    typedef struct packed {
        logic [IDX_W-1:0]   best_idx;
        logic [SCORE_W-1:0] best_score;
        logic [IDX_W-1:0]   sec_idx;
        logic [SCORE_W-1:0] sec_score;
        logic               sec_valid;
    } top2_t;

    // Strict greater-than under the selected arithmetic; equality is never a win,
    // which is what keeps the lower index on ties.
    function automatic logic score_gt(input logic [SCORE_W-1:0] a,
                                      input logic [SCORE_W-1:0] b,
                                      input logic               signed_mode);
        if (signed_mode) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

endpackage

// File: rtl/score_argmax_tracker_top2_update.sv
// Next-state of the running top-2 given one new (index, score) beat.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module score_argmax_tracker_top2_update
    import score_argmax_tracker_pkg::*;
#(
    parameter bit SIGNED_MODE = 1'b0
) (
    input  logic               first,
    input  top2_t              cur,
    input  logic [IDX_W-1:0]   idx,
    input  logic [SCORE_W-1:0] score,
    output top2_t              nxt
);

    // Beat 0 restarts the frame; later beats displace best, else displace runner-up.
    always_comb begin
        nxt = cur;
        if (first) begin
            nxt.best_idx   = idx;
            nxt.best_score = score;
            nxt.sec_idx    = '0;
            nxt.sec_score  = '0;
            nxt.sec_valid  = 1'b0;
        end else if (score_gt(score, cur.best_score, SIGNED_MODE)) begin
            nxt.sec_idx    = cur.best_idx;
            nxt.sec_score  = cur.best_score;
            nxt.sec_valid  = 1'b1;
            nxt.best_idx   = idx;
            nxt.best_score = score;
        end else if (!cur.sec_valid || score_gt(score, cur.sec_score, SIGNED_MODE)) begin
            nxt.sec_idx    = idx;
            nxt.sec_score  = score;
            nxt.sec_valid  = 1'b1;
        end
    end

endmodule

// File: rtl/score_argmax_tracker.sv
// Streaming top-2 decision unit: per-frame winner, margin, confidence, debounced class, readback.
// Latency: Out_Valid pulses the cycle after the one-cycle COMMIT state that follows the last beat.
// Backpressure: In_Ready drops for exactly the COMMIT cycle of each frame (and during reset).
module score_argmax_tracker
    import score_argmax_tracker_pkg::*;
#(
    parameter int                 SIGNED_MODE   = 0,
    parameter logic [SCORE_W-1:0] CONF_MARGIN   = 16'h0800,
    parameter int                 STABLE_FRAMES = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               In_Valid,
    output logic               In_Ready,
    input  logic [SCORE_W-1:0] In_Score,
    input  logic               In_Last,
    output logic               Out_Valid,
    output logic [IDX_W-1:0]   Out_Class,
    output logic [SCORE_W-1:0] Out_Score,
    output logic [IDX_W-1:0]   Out_Second,
    output logic [SCORE_W-1:0] Out_Margin,
    output logic               Out_Confident,
    output logic               Stable_Valid,
    output logic [IDX_W-1:0]   Stable_Class,
    input  logic [IDX_W-1:0]   Sel_Index,
    output logic [SCORE_W-1:0] Sel_Score,
    output logic               Frame_Err
);

    localparam int                 RUN_W    = $clog2(STABLE_FRAMES + 1);
    localparam logic [RUN_W-1:0]   RUN_MAX  = RUN_W'(STABLE_FRAMES);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W:0]     NUM_EXT  = (IDX_W + 1)'(NUM_CLASSES);

    logic [0:0]         state;
    logic [IDX_W-1:0]   beat_cnt;
    top2_t              top2_q;
    top2_t              top2_nxt;
    logic [SCORE_W-1:0] shadow [NUM_CLASSES];
    logic [SCORE_W-1:0] bank   [NUM_CLASSES];
    logic [RUN_W-1:0]   run_cnt;
    logic [RUN_W-1:0]   run_nxt;
    logic [SCORE_W:0]   best_ext;
    logic [SCORE_W:0]   sec_ext;
    logic [SCORE_W:0]   diff;
    logic [SCORE_W-1:0] margin_nxt;
    logic               conf_nxt;
    logic               beat_acc;
    logic               beat_final;
    logic               frame_bad;
    logic               frame_done;

    // Ready is also gated by the raw reset so nothing is accepted while it is held.
    assign In_Ready   = Reset_n & (state == ST_ACCUM);
    assign beat_acc   = In_Valid & In_Ready;
    assign beat_final = (beat_cnt == LAST_IDX);
    assign frame_bad  = beat_acc & (In_Last ^ beat_final);
    assign frame_done = beat_acc & In_Last & beat_final;

    score_argmax_tracker_top2_update #(
        .SIGNED_MODE (SIGNED_MODE != 0)
    ) u_top2_update (
        .first (beat_cnt == '0),
        .cur   (top2_q),
        .idx   (beat_cnt),
        .score (In_Score),
        .nxt   (top2_nxt)
    );

    // Margin one bit wider than the scores so the signed range cannot wrap; saturate on overflow.
    always_comb begin
        if (SIGNED_MODE != 0) begin
            best_ext = {top2_q.best_score[SCORE_W-1], top2_q.best_score};
            sec_ext  = {top2_q.sec_score[SCORE_W-1], top2_q.sec_score};
        end else begin
            best_ext = {1'b0, top2_q.best_score};
            sec_ext  = {1'b0, top2_q.sec_score};
        end
        diff       = best_ext - sec_ext;
        margin_nxt = diff[SCORE_W] ? '1 : diff[SCORE_W-1:0];
        conf_nxt   = (margin_nxt >= CONF_MARGIN);
    end

    // Run length of confident identical winners, compared against the class committed last time.
    always_comb begin
        run_nxt = '0;
        if (conf_nxt) begin
            if (top2_q.best_idx == Out_Class) begin
                run_nxt = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + 1'b1;
            end else begin
                run_nxt = RUN_W'(1);
            end
        end
    end

    // Frame sequencing: beat counting, running top-2, framing error and the commit state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_ACCUM;
            beat_cnt  <= '0;
            top2_q    <= '0;
            Frame_Err <= 1'b0;
        end else begin
            if (state == ST_COMMIT) begin
                state <= ST_ACCUM;
            end else if (frame_done) begin
                state <= ST_COMMIT;
            end
            if (beat_acc) begin
                beat_cnt <= (frame_bad || frame_done) ? '0 : beat_cnt + 1'b1;
                top2_q   <= top2_nxt;
            end
            if (frame_bad) begin
                Frame_Err <= 1'b1;
            end
        end
    end

    // Shadow copy of the frame in flight; only a committed frame reaches the readback bank.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                shadow[i] <= '0;
            end
        end else if (beat_acc) begin
            shadow[beat_cnt] <= In_Score;
        end
    end

    // Commit: result registers, readback bank and debounce state load on leaving COMMIT.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Out_Valid     <= 1'b0;
            Out_Class     <= '0;
            Out_Score     <= '0;
            Out_Second    <= '0;
            Out_Margin    <= '0;
            Out_Confident <= 1'b0;
            Stable_Valid  <= 1'b0;
            Stable_Class  <= '0;
            run_cnt       <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                bank[i] <= '0;
            end
        end else begin
            Out_Valid <= (state == ST_COMMIT);
            if (state == ST_COMMIT) begin
                Out_Class     <= top2_q.best_idx;
                Out_Score     <= top2_q.best_score;
                Out_Second    <= top2_q.sec_idx;
                Out_Margin    <= margin_nxt;
                Out_Confident <= conf_nxt;
                run_cnt       <= run_nxt;
                bank          <= shadow;
                if (run_nxt == RUN_MAX) begin
                    Stable_Class <= top2_q.best_idx;
                    Stable_Valid <= 1'b1;
                end
            end
        end
    end

    // Readback of the committed frame; out-of-range selects read as zero.
    always_comb begin
        Sel_Score = '0;
        if ({1'b0, Sel_Index} < NUM_EXT) begin
            Sel_Score = bank[Sel_Index];
        end
    end

endmodule
